// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and types for the 640x480@60 VGA timing generator:
//   - raw horizontal/vertical timing (active, porches, sync width)
//   - derived line/frame totals and sync start/end positions
//   - counter widths for the horizontal counter, vertical counter and the
//     linear image address
//   - default image size used for address generation
//   - phase enum shared by the horizontal and vertical state machines
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal timing, in pixels
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Derived totals and sync windows [start, end)
  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;  // 800
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;  // 525
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;                          // 656
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;                    // 752
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;                          // 490
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;                    // 492

  // Image size for the frame-address generator
  localparam int VGA_IMG_W = 400;
  localparam int VGA_IMG_H = 300;

  // Counter widths
  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int ADDR_W  = 17;

  // Raster phase, used for both the line and the frame state machine
  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_timing_gen_pix_tick_div.sv
// -----------------------------------------------------------------------------
// pix_tick_div
// Divides the system clock down to the pixel rate.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   pix_tick  out  registered one-clk pulse, high while the divider sits at
//                  CLK_DIV-1 (constantly high after reset when CLK_DIV==1)
// CLK_DIV must lie in 1..16 so the divider fits in 4 bits.
// -----------------------------------------------------------------------------
module pix_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_reg;
  logic [3:0] div_next;
  logic       tick_next;

  // The tick is derived from the next divider value so that the registered
  // pulse lines up with the clk in which the divider holds CLK_DIV-1.
  always_comb begin
    div_next  = (div_reg == DIV_LAST) ? 4'd0 : div_reg + 4'd1;
    tick_next = (div_next == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg  <= 4'd0;
      pix_tick <= 1'b0;
    end else begin
      div_reg  <= div_next;
      pix_tick <= tick_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing for the RGB pixel loader (640x480@60 by default).
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   pix_tick         out  one-clk pulse per pixel period
//   count_rgb        out  horizontal counter 0..H_TOTAL-1
//   reset_count_rgb  out  vertical counter 0..V_TOTAL-1
//   hsync / vsync    out  sync outputs, active level SYNC_POL
//   active           out  visible-region flag
//   frame_start      out  one-clk pulse on the (last,last)->(0,0) transition
//   pix_addr         out  linear image address (only with
//                         VGA_TIMING_FRAME_ADDR_EN defined)
// Counters and all outputs advance only on pix_tick. Outputs are registered
// from next-state values so they change on the same edge as the counters.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int IMG_W    = VGA_IMG_W,
  parameter int IMG_H    = VGA_IMG_H
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               pix_tick,
  output logic [H_CNT_W-1:0] count_rgb,
  output logic [V_CNT_W-1:0] reset_count_rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               frame_start
`ifdef VGA_TIMING_FRAME_ADDR_EN
  ,
  output logic [ADDR_W-1:0]  pix_addr
`endif
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [H_CNT_W-1:0] h_cnt_reg, h_cnt_next;
  logic [V_CNT_W-1:0] v_cnt_reg, v_cnt_next;
  phase_e             h_state_reg, h_state_next;
  phase_e             v_state_reg, v_state_next;
  logic               hsync_reg, hsync_next;
  logic               vsync_reg, vsync_next;
  logic               active_reg, active_next;
  logic               frame_start_reg, frame_start_next;
  logic               line_wrap;
  logic               frame_wrap;

  pix_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick)
  );

  always_comb begin
    h_cnt_next       = h_cnt_reg;
    v_cnt_next       = v_cnt_reg;
    h_state_next     = h_state_reg;
    v_state_next     = v_state_reg;
    hsync_next       = hsync_reg;
    vsync_next       = vsync_reg;
    active_next      = active_reg;
    frame_start_next = 1'b0;
    line_wrap        = 1'b0;
    frame_wrap       = 1'b0;

    if (pix_tick) begin
      if (h_cnt_reg == H_CNT_W'(H_TOTAL - 1)) begin
        h_cnt_next = '0;
        line_wrap  = 1'b1;
      end else begin
        h_cnt_next = h_cnt_reg + 1'b1;
      end

      // Phase transitions look at the counter value being entered, so the
      // state always describes h_cnt_next.
      unique case (h_state_reg)
        PH_ACT:  if (h_cnt_next == H_CNT_W'(H_ACTIVE))     h_state_next = PH_FP;
        PH_FP:   if (h_cnt_next == H_CNT_W'(H_SYNC_START)) h_state_next = PH_SYNC;
        PH_SYNC: if (h_cnt_next == H_CNT_W'(H_SYNC_END))   h_state_next = PH_BP;
        PH_BP:   if (line_wrap)                            h_state_next = PH_ACT;
        default: h_state_next = PH_ACT;
      endcase

      if (line_wrap) begin
        if (v_cnt_reg == V_CNT_W'(V_TOTAL - 1)) begin
          v_cnt_next = '0;
          frame_wrap = 1'b1;
        end else begin
          v_cnt_next = v_cnt_reg + 1'b1;
        end

        unique case (v_state_reg)
          PH_ACT:  if (v_cnt_next == V_CNT_W'(V_ACTIVE))     v_state_next = PH_FP;
          PH_FP:   if (v_cnt_next == V_CNT_W'(V_SYNC_START)) v_state_next = PH_SYNC;
          PH_SYNC: if (v_cnt_next == V_CNT_W'(V_SYNC_END))   v_state_next = PH_BP;
          PH_BP:   if (frame_wrap)                           v_state_next = PH_ACT;
          default: v_state_next = PH_ACT;
        endcase
      end

      hsync_next       = (h_state_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_next       = (v_state_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      active_next      = (h_state_next == PH_ACT) && (v_state_next == PH_ACT);
      frame_start_next = frame_wrap;
    end
  end

  // active starts at 0 although the raster sits at (0,0): the flag only
  // becomes meaningful once the first pixel period has elapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      h_state_reg     <= PH_ACT;
      v_state_reg     <= PH_ACT;
      hsync_reg       <= ~SYNC_POL;
      vsync_reg       <= ~SYNC_POL;
      active_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      h_cnt_reg       <= h_cnt_next;
      v_cnt_reg       <= v_cnt_next;
      h_state_reg     <= h_state_next;
      v_state_reg     <= v_state_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      active_reg      <= active_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign count_rgb       = h_cnt_reg;
  assign reset_count_rgb = v_cnt_reg;
  assign hsync           = hsync_reg;
  assign vsync           = vsync_reg;
  assign active          = active_reg;
  assign frame_start     = frame_start_reg;

`ifdef VGA_TIMING_FRAME_ADDR_EN
  logic [ADDR_W-1:0] addr_reg, addr_next;

  // Counting instead of multiplying: inside the image the row-major index of
  // the next position is always the previous in-image index plus one, and
  // (0,0) is the only place the sequence restarts.
  always_comb begin
    addr_next = addr_reg;
    if (pix_tick) begin
      if (frame_wrap) begin
        addr_next = '0;
      end else if ((h_cnt_next < H_CNT_W'(IMG_W)) && (v_cnt_next < V_CNT_W'(IMG_H))) begin
        addr_next = addr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
    end else begin
      addr_reg <= addr_next;
    end
  end

  assign pix_addr = addr_reg;
`endif

  // Counters can never leave their range, and the image must fit inside the
  // visible region for the address sequence to be contiguous.
  assert property (@(posedge clk) disable iff (!rst_n)
    (h_cnt_reg < H_CNT_W'(H_TOTAL)) && (v_cnt_reg < V_CNT_W'(V_TOTAL)) &&
    (IMG_W <= H_ACTIVE) && (IMG_H <= V_ACTIVE));

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream timing stage for the RGB pixel loader. Produces the horizontal pixel counter (count_rgb), the vertical line counter (reset_count_rgb), and the HSYNC/VSYNC/active/frame pulses for a 640x480@60 VGA raster.
- Derives a pixel-rate tick from the system clock.
- All counters advance only on that tick, so downstream stages clocked on clk stay cycle-aligned.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
- IMG_W, 400, image width for address generation
- IMG_H, 300, image height for address generation

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_tick  out  1  one-clk pulse per pixel period
- count_rgb  out  11  horizontal counter, 0..H_TOTAL-1 (H_TOTAL=800)
- reset_count_rgb  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL=525)
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  visible-region flag
- frame_start  out  1  one-clk pulse at frame origin
- pix_addr  out  17  linear image address (present only with the optional feature)

Behaviour:
- Reset (async assert, sync release) values:
  - divider=0, pix_tick=0
  - count_rgb=0, reset_count_rgb=0
  - hsync=vsync=~SYNC_POL
  - active=0, frame_start=0, pix_addr=0
- Divider:
  - div counts 0..CLK_DIV-1 every clk.
  - pix_tick is registered; it is high for the one clk in which div==CLK_DIV-1.
  - CLK_DIV=1 gives pix_tick constantly high after reset.
- Horizontal FSM (advances on pix_tick), states H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT:
  - Boundaries at h = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, and H_TOTAL-1 (wrap to 0).
- Vertical FSM, states V_ACT/V_FP/V_SYNC/V_BP:
  - Advances only on a pix_tick where h wraps (799->0).
  - v wraps 524->0 on the same tick.
- Output timing:
  - All outputs are registered and computed from next-state counters, so hsync/vsync/active change on the same clk edge as the counters they describe.
  - hsync = SYNC_POL while h in [656,752), else ~SYNC_POL.
  - vsync = SYNC_POL while v in [490,492), else ~SYNC_POL.
  - active = (h<H_ACTIVE && v<V_ACTIVE). It stays 0 from reset until the first pix_tick.
  - frame_start = 1 for exactly one clk, on the edge where the counters transition to (0,0) from (799,524). No pulse on reset release.
  - Between ticks all counter and sync outputs hold.
- Width rules: counters compare with full-width unsigned constants. No counter ever exceeds TOTAL-1. Out-of-range values are impossible by construction; an assertion checks this.
- Reset mid-frame: every output returns to its reset value immediately (asynchronous). The raster restarts at (0,0) with the divider restarted.

Optional Feature:
- Macro VGA_TIMING_FRAME_ADDR_EN.
- Defined:
  - pix_addr port exists.
  - On each pix_tick where the next (h,v) has h<IMG_W and v<IMG_H, pix_addr is the next linear index. Sequence is 0..IMG_W*IMG_H-1 (0..119999).
  - pix_addr returns to 0 on frame_start.
  - pix_addr holds outside the image region.
  - This is the address source for the image ROM read.
- Undefined:
  - pix_addr port and its logic are absent.
  - The downstream loader keeps its own address counter.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480 timing constants.
  - Derived H_TOTAL/V_TOTAL and sync start/end localparams.
  - Enum typedefs for the phase states {ACT, FP, SYNC, BP}.
  - Counter-width constants (11, 10, 17).
- One sub-module, pix_tick_div: CLK_DIV divider producing pix_tick.
- Horizontal and vertical FSMs stay in the top level.

Test Plan:
- Reset then run 1 line, CLK_DIV=4 -> pix_tick every 4th clk; count_rgb steps 0..799, wraps to 0 after 3200 clks; reset_count_rgb increments to 1 at the wrap.
- Sync edges -> hsync low for exactly 96 ticks starting at count_rgb=656; vsync low for exactly 2 lines starting at reset_count_rgb=490; both high elsewhere.
- Active window -> active=1 for 640 ticks per line on lines 0..479, 0 on lines 480..524; active=0 before the first tick.
- Full frame -> frame_start pulses once per 420000 ticks, coincident with the (799,524)->(0,0) transition, width 1 clk.
- Assert rst_n low mid-line (count_rgb=300, reset_count_rgb=200) -> all outputs reset immediately; after release the first tick gives count_rgb=1 and no frame_start.
- With VGA_TIMING_FRAME_ADDR_EN -> pix_addr reaches 399 at (399,0), 400 at (0,1), 119999 at (399,299), holds until frame_start, then returns to 0.
